riscv_dmem_responder: RTL and testbench
=======================================

Name: riscv_dmem_responder

Overview:
- Memory-side responder for the core's data port when caches are disabled (DIS_CACHE build).
- Uses the core's req/gnt/rvalid protocol: the core issues data_req_o, data_addr_o, data_we_o, data_be_o and data_wdata_o, and samples data_gnt_i, data_rvalid_i and data_rdata_i.
- Backs the port with a word-organised on-chip RAM.
- Has a configurable fixed response latency, a bounded number of outstanding transactions and a grant-stall input, so the core's load/store unit can be exercised under backpressure.

Parameters:
- MEM_WORDS, 4096, RAM depth in 32-bit words (power of two, ≥ 4).
- BASE_ADDR, 34'h0, byte address of word 0. Must be 4-byte aligned.
- LATENCY, 1, cycles from the grant cycle to the rvalid cycle. Legal range 1..4.
- MAX_OUTSTANDING, 2, maximum number of granted transactions without rvalid. Legal range 1..LATENCY+1.
- OOR_RDATA, 32'hDEAD_BEEF, read data returned for out-of-range reads.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- data_req_i  in  1  core request valid.
- data_addr_i  in  34  byte address.
- data_we_i  in  1  1 = store, 0 = load.
- data_be_i  in  4  byte enables; bit n enables wdata[8n+7:8n].
- data_wdata_i  in  32  store data.
- data_gnt_o  out  1  request accepted this cycle.
- data_rvalid_o  out  1  response valid; the core accepts it unconditionally.
- data_rdata_o  out  32  load data, valid while data_rvalid_o = 1.
- stall_i  in  1  test backpressure; forces data_gnt_o to 0.
- oor_o  out  1  one-cycle pulse when an out-of-range access is granted.

Interface decision: one clock, clk_i; reset rst_ni is asynchronous and active-low.

Behaviour:
- Reset (rst_ni = 0, takes effect immediately):
  - data_gnt_o = 0, data_rvalid_o = 0, data_rdata_o = 0, oor_o = 0.
  - Outstanding counter = 0; response pipeline cleared.
  - RAM contents are not reset.
- Reset mid-operation: all in-flight responses are discarded; no rvalid follows reset release for pre-reset grants.
- Address decode (34-bit arithmetic, no wrap):
  - In range iff BASE_ADDR ≤ addr < BASE_ADDR + 4*MEM_WORDS.
  - Word index = (addr − BASE_ADDR) >> 2; addr[1:0] is ignored.
- Grant (combinational):
  - gnt = req & ~stall_i & (outstanding < MAX_OUTSTANDING | retire), where retire = data_rvalid_o in the current cycle.
  - While rst_ni = 0, gnt = 0.
  - gnt has no combinational dependence on addr, we, be or wdata.
- Handshake:
  - A transaction is accepted on a clock edge with req & gnt.
  - The core holds req and the attributes stable until granted. The responder does not check this.
- Memory access, performed at the accepting edge:
  - In-range store: write only the enabled bytes. be = 4'b0000 writes nothing but still produces a response.
  - In-range load: read the full word.
  - Out-of-range store: dropped.
  - Out-of-range load: returns OOR_RDATA.
  - Out-of-range access of either kind: oor_o = 1 in the cycle after acceptance.
- Response pipeline:
  - LATENCY-stage shift register of {valid, rdata}. Stage 0 is loaded at the accepting edge; the last stage drives data_rvalid_o/data_rdata_o.
  - rvalid is asserted exactly LATENCY cycles after the grant cycle. LATENCY = 1 means the next cycle.
  - Every accepted transaction produces exactly one rvalid, in grant order.
  - Stores return rdata = 32'h0.
  - When rvalid = 0, data_rdata_o holds 0.
- Outstanding counter, width $clog2(MAX_OUTSTANDING+1):
  - +1 on accept, −1 on retire; unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUTSTANDING. Assert this with an SVA property.
- Back-to-back: with MAX_OUTSTANDING ≥ LATENCY and no stall, one transaction per cycle is sustained.
- Read-after-write ordering: a load granted in the cycle after a store to the same word returns the stored data (write-first ordering by sequence).
- Simultaneous stall_i and retire: the retire still completes; gnt stays 0.

Decomposition:
- Shared package riscv_package receives:
  - typedef dmem_resp_t {logic valid; logic [31:0] rdata}.
  - localparam DMEM_MAX_LATENCY = 4.
- Natural sub-module: riscv_dmem_ram.
  - Single-port, MEM_WORDS × 32, per-byte write enable.
  - Write and read on the same edge; read data is registered into pipeline stage 0.
- Counter, decode and pipeline stay in the top module.

Test Plan:
1. Reset with LATENCY = 1: store addr 0x10, be 4'hF, wdata 0x12345678, then load 0x10 → gnt in both request cycles; load rvalid one cycle after its grant with rdata 0x12345678; store rvalid rdata 0.
2. Byte enables: word 0x20 holds 0xAABBCCDD; store be 4'b0101, wdata 0x11223344, then load 0x20 → 0xAA22CC44.
3. LATENCY = 3, MAX_OUTSTANDING = 2, continuous loads → grants at cycles 0 and 1, gnt low at cycle 2, then grant at cycle 3 (retire cycle). Responses in order at cycles 3, 4, 6; counter never exceeds 2.
4. Out-of-range: BASE_ADDR 0x1000, MEM_WORDS 16 → load 0x1040 returns 0xDEADBEEF with oor_o pulse. Store to 0x0FFC is dropped (load 0x0FFC + 0x1000 boundary words unchanged), oor_o pulses.
5. stall_i = 1 for 5 cycles with req held → no gnt; pending rvalid still delivered; grant in the first cycle after stall_i falls.
6. Assert rst_ni low with 2 transactions outstanding (LATENCY = 3) → rvalid drops immediately; after release, no rvalid appears without a new grant, and the counter reads 0.

Source files
------------

// File: rtl/riscv_dmem_responder_pkg.sv
// Shared types for the data-memory responder: the response pipeline entry
// and the selector for where stage 0 takes its read data from.
package riscv_package;

   localparam int DMEM_MAX_LATENCY = 4;

   typedef struct packed {
      logic        valid;
      logic [31:0] rdata;
   } dmem_resp_t;

   // A store answers with zero, an in-range load with RAM data and an
   // out-of-range load with the fixed pattern.
   typedef enum logic [1:0] {
      SRC_ZERO = 2'd0,
      SRC_RAM  = 2'd1,
      SRC_OOR  = 2'd2
   } rdata_src_e;

endpackage

// File: rtl/riscv_dmem_responder_ram.sv
// Single-port word RAM with per-byte write enables and a registered read
// port. The registered read data forms the data half of response stage 0.
module riscv_dmem_ram #(
   parameter int MEM_WORDS = 4096,
   parameter int AW        = $clog2(MEM_WORDS)
) (
   input  logic          clk_i,
   input  logic          en,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [MEM_WORDS];

   // One access per edge: either a byte-masked write or a full-word read.
   always_ff @(posedge clk_i) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) begin
                  mem[addr][8*b +: 8] <= wdata[8*b +: 8];
               end
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Memory-side responder for the core's req/gnt/rvalid data port. Grants are
// throttled by an outstanding-transaction counter and a stall input, and every
// accepted request is answered exactly LATENCY cycles after its grant.
module riscv_dmem_responder
   import riscv_package::*;
#(
   parameter int          MEM_WORDS       = 4096,
   parameter logic [33:0] BASE_ADDR       = 34'h0,
   parameter int          LATENCY         = 1,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] OOR_RDATA       = 32'hDEAD_BEEF
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        data_req_i,
   input  logic [33:0] data_addr_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   input  logic        stall_i,
   output logic        oor_o
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [34:0] BASE_EXT  = {1'b0, BASE_ADDR};
   localparam logic [34:0] LIMIT_EXT = BASE_EXT + 35'(4 * MEM_WORDS);

   // Decode is done with one spare bit so the upper bound never wraps.
   logic [34:0]   addr_ext;
   logic          in_range;
   logic [AW-1:0] word_idx;

   assign addr_ext = {1'b0, data_addr_i};
   assign in_range = (addr_ext >= BASE_EXT) && (addr_ext < LIMIT_EXT);
   assign word_idx = AW'((addr_ext - BASE_EXT) >> 2);

   logic [CW-1:0] cnt_reg;
   logic          retire;
   logic          accept;

   // A retiring response frees its slot in the same cycle, so a full counter
   // does not block the grant when rvalid is high.
   assign retire     = data_rvalid_o;
   assign data_gnt_o = rst_ni & data_req_i & ~stall_i
                     & ((cnt_reg < CW'(MAX_OUTSTANDING)) | retire);
   assign accept     = data_req_i & data_gnt_o;

   logic [31:0] ram_rdata;

   riscv_dmem_ram #(
      .MEM_WORDS (MEM_WORDS),
      .AW        (AW)
   ) u_ram (
      .clk_i (clk_i),
      .en    (accept & in_range),
      .we    (data_we_i),
      .be    (data_be_i),
      .addr  (word_idx),
      .wdata (data_wdata_i),
      .rdata (ram_rdata)
   );

   // Track granted-but-unanswered transactions.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_reg <= '0;
      end else begin
         case ({accept, retire})
            2'b10:   cnt_reg <= cnt_reg + 1'b1;
            2'b01:   cnt_reg <= cnt_reg - 1'b1;
            default: cnt_reg <= cnt_reg;
         endcase
      end
   end

   // Stage 0 control half: valid plus the source of its read data.
   logic       s0_valid_reg;
   rdata_src_e s0_src_reg;
   logic       oor_reg;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s0_valid_reg <= 1'b0;
         s0_src_reg   <= SRC_ZERO;
         oor_reg      <= 1'b0;
      end else begin
         s0_valid_reg <= accept;
         oor_reg      <= accept & ~in_range;
         if (!accept || data_we_i) begin
            s0_src_reg <= SRC_ZERO;
         end else if (in_range) begin
            s0_src_reg <= SRC_RAM;
         end else begin
            s0_src_reg <= SRC_OOR;
         end
      end
   end

   // Assemble the stage 0 entry from the control register and RAM output.
   dmem_resp_t s0_resp;

   always_comb begin
      s0_resp.valid = s0_valid_reg;
      s0_resp.rdata = '0;
      if (s0_valid_reg) begin
         case (s0_src_reg)
            SRC_RAM: s0_resp.rdata = ram_rdata;
            SRC_OOR: s0_resp.rdata = OOR_RDATA;
            default: s0_resp.rdata = '0;
         endcase
      end
   end

   dmem_resp_t resp_out;

   if (LATENCY == 1) begin : g_lat1
      assign resp_out = s0_resp;
   end else begin : g_pipe
      dmem_resp_t stage_reg [LATENCY-1];

      // Remaining delay stages; reset discards anything in flight.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int i = 0; i < LATENCY - 1; i++) begin
               stage_reg[i] <= '0;
            end
         end else begin
            stage_reg[0] <= s0_resp;
            for (int i = 1; i < LATENCY - 1; i++) begin
               stage_reg[i] <= stage_reg[i-1];
            end
         end
      end

      assign resp_out = stage_reg[LATENCY-2];
   end

   assign data_rvalid_o = resp_out.valid;
   assign data_rdata_o  = resp_out.valid ? resp_out.rdata : 32'h0;
   assign oor_o         = oor_reg;

   // The grant throttle must keep the counter within its configured bound.
   a_cnt_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
      cnt_reg <= CW'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench: three responder instances cover latency 1, latency 3 with
// backpressure and reset, and an offset/out-of-range configuration.
module tb_riscv_dmem_responder;

   logic clk;
   logic rst_n;

   logic        a_req, a_we, a_stall, a_gnt, a_rvalid, a_oor;
   logic [33:0] a_addr;
   logic [3:0]  a_be;
   logic [31:0] a_wdata, a_rdata;

   logic        b_req, b_we, b_stall, b_gnt, b_rvalid, b_oor;
   logic [33:0] b_addr;
   logic [3:0]  b_be;
   logic [31:0] b_wdata, b_rdata;

   logic        c_req, c_we, c_stall, c_gnt, c_rvalid, c_oor;
   logic [33:0] c_addr;
   logic [3:0]  c_be;
   logic [31:0] c_wdata, c_rdata;

   int checks = 0;
   int errors = 0;

   riscv_dmem_responder #(
      .MEM_WORDS(64), .BASE_ADDR(34'h0), .LATENCY(1), .MAX_OUTSTANDING(2),
      .OOR_RDATA(32'hDEAD_BEEF)
   ) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .data_req_i(a_req), .data_addr_i(a_addr),
      .data_we_i(a_we), .data_be_i(a_be), .data_wdata_i(a_wdata),
      .data_gnt_o(a_gnt), .data_rvalid_o(a_rvalid), .data_rdata_o(a_rdata),
      .stall_i(a_stall), .oor_o(a_oor)
   );

   riscv_dmem_responder #(
      .MEM_WORDS(64), .BASE_ADDR(34'h0), .LATENCY(3), .MAX_OUTSTANDING(2),
      .OOR_RDATA(32'hDEAD_BEEF)
   ) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .data_req_i(b_req), .data_addr_i(b_addr),
      .data_we_i(b_we), .data_be_i(b_be), .data_wdata_i(b_wdata),
      .data_gnt_o(b_gnt), .data_rvalid_o(b_rvalid), .data_rdata_o(b_rdata),
      .stall_i(b_stall), .oor_o(b_oor)
   );

   riscv_dmem_responder #(
      .MEM_WORDS(16), .BASE_ADDR(34'h1000), .LATENCY(1), .MAX_OUTSTANDING(2),
      .OOR_RDATA(32'hDEAD_BEEF)
   ) dut_c (
      .clk_i(clk), .rst_ni(rst_n), .data_req_i(c_req), .data_addr_i(c_addr),
      .data_we_i(c_we), .data_be_i(c_be), .data_wdata_i(c_wdata),
      .data_gnt_o(c_gnt), .data_rvalid_o(c_rvalid), .data_rdata_o(c_rdata),
      .stall_i(c_stall), .oor_o(c_oor)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Single store on instance B, then idle until its response has drained.
   task automatic b_store(input logic [33:0] addr, input logic [31:0] data);
      @(negedge clk);
      b_req = 1'b1; b_we = 1'b1; b_addr = addr; b_be = 4'hF; b_wdata = data;
      #1 chk("b_preload_gnt", 32'(b_gnt), 32'd1);
      @(negedge clk);
      b_req = 1'b0; b_we = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      a_req = 1'b1; a_we = 1'b0; a_addr = '0; a_be = 4'hF; a_wdata = '0; a_stall = 1'b0;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_be = 4'hF; b_wdata = '0; b_stall = 1'b0;
      c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_be = 4'hF; c_wdata = '0; c_stall = 1'b0;

      // Reset state, with a request pending that must not be granted.
      @(negedge clk);
      #1;
      chk("rst_gnt", 32'(a_gnt), 32'd0);
      chk("rst_rvalid", 32'(a_rvalid), 32'd0);
      chk("rst_rdata", a_rdata, 32'h0);
      chk("rst_oor", 32'(a_oor), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; a_req = 1'b0;

      // Store then load, latency 1.
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b1; a_addr = 34'h10; a_be = 4'hF; a_wdata = 32'h1234_5678;
      #1 chk("t1_st_gnt", 32'(a_gnt), 32'd1);
      chk("t1_st_rvalid_early", 32'(a_rvalid), 32'd0);
      @(negedge clk);
      a_we = 1'b0;
      #1 chk("t1_ld_gnt", 32'(a_gnt), 32'd1);
      chk("t1_st_rvalid", 32'(a_rvalid), 32'd1);
      chk("t1_st_rdata", a_rdata, 32'h0);
      @(negedge clk);
      a_req = 1'b0;
      #1 chk("t1_ld_rvalid", 32'(a_rvalid), 32'd1);
      chk("t1_ld_rdata", a_rdata, 32'h1234_5678);
      @(negedge clk);
      #1 chk("t1_idle_rvalid", 32'(a_rvalid), 32'd0);
      chk("t1_idle_rdata", a_rdata, 32'h0);

      // Byte enables with a read-after-write in the very next cycle.
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b1; a_addr = 34'h20; a_be = 4'hF; a_wdata = 32'hAABB_CCDD;
      #1 chk("t2_st0_gnt", 32'(a_gnt), 32'd1);
      @(negedge clk);
      a_be = 4'b0101; a_wdata = 32'h1122_3344;
      #1 chk("t2_st1_gnt", 32'(a_gnt), 32'd1);
      @(negedge clk);
      a_we = 1'b0; a_be = 4'hF;
      #1 chk("t2_ld_gnt", 32'(a_gnt), 32'd1);
      @(negedge clk);
      a_req = 1'b0;
      #1 chk("t2_ld_rvalid", 32'(a_rvalid), 32'd1);
      chk("t2_ld_rdata", a_rdata, 32'hAA22_CC44);

      // Latency 3, two outstanding, continuous loads.
      b_store(34'h0, 32'hA0A0_A0A0);
      b_store(34'h4, 32'hB1B1_B1B1);
      b_store(34'h8, 32'hC2C2_C2C2);
      @(negedge clk);
      b_req = 1'b1; b_we = 1'b0; b_addr = 34'h0;
      #1 chk("t3_c0_gnt", 32'(b_gnt), 32'd1);
      chk("t3_c0_rvalid", 32'(b_rvalid), 32'd0);
      @(negedge clk);
      b_addr = 34'h4;
      #1 chk("t3_c1_gnt", 32'(b_gnt), 32'd1);
      @(negedge clk);
      b_addr = 34'h8;
      #1 chk("t3_c2_gnt", 32'(b_gnt), 32'd0);
      chk("t3_c2_rvalid", 32'(b_rvalid), 32'd0);
      @(negedge clk);
      #1 chk("t3_c3_gnt", 32'(b_gnt), 32'd1);
      chk("t3_c3_rvalid", 32'(b_rvalid), 32'd1);
      chk("t3_c3_rdata", b_rdata, 32'hA0A0_A0A0);
      @(negedge clk);
      b_req = 1'b0;
      #1 chk("t3_c4_rvalid", 32'(b_rvalid), 32'd1);
      chk("t3_c4_rdata", b_rdata, 32'hB1B1_B1B1);
      @(negedge clk);
      #1 chk("t3_c5_rvalid", 32'(b_rvalid), 32'd0);
      @(negedge clk);
      #1 chk("t3_c6_rvalid", 32'(b_rvalid), 32'd1);
      chk("t3_c6_rdata", b_rdata, 32'hC2C2_C2C2);
      @(negedge clk);
      #1 chk("t3_c7_rvalid", 32'(b_rvalid), 32'd0);

      // Stall for five cycles while a response is still in flight.
      @(negedge clk);
      b_req = 1'b1; b_addr = 34'h0;
      #1 chk("t5_first_gnt", 32'(b_gnt), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         b_stall = 1'b1; b_addr = 34'h4;
         #1 chk($sformatf("t5_stall%0d_gnt", i), 32'(b_gnt), 32'd0);
         if (i == 2) begin
            chk("t5_stall_rvalid", 32'(b_rvalid), 32'd1);
            chk("t5_stall_rdata", b_rdata, 32'hA0A0_A0A0);
         end
      end
      @(negedge clk);
      b_stall = 1'b0;
      #1 chk("t5_release_gnt", 32'(b_gnt), 32'd1);
      @(negedge clk);
      b_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 chk("t5_late_rvalid", 32'(b_rvalid), 32'd1);
      chk("t5_late_rdata", b_rdata, 32'hB1B1_B1B1);
      @(negedge clk);

      // Reset with two transactions outstanding.
      @(negedge clk);
      b_req = 1'b1; b_addr = 34'h0;
      #1 chk("t6_c0_gnt", 32'(b_gnt), 32'd1);
      @(negedge clk);
      b_addr = 34'h8;
      #1 chk("t6_c1_gnt", 32'(b_gnt), 32'd1);
      @(negedge clk);
      b_req = 1'b0;
      @(negedge clk);
      #1 chk("t6_pre_rvalid", 32'(b_rvalid), 32'd1);
      rst_n = 1'b0; b_req = 1'b1;
      #1 chk("t6_rst_rvalid", 32'(b_rvalid), 32'd0);
      chk("t6_rst_rdata", b_rdata, 32'h0);
      chk("t6_rst_gnt", 32'(b_gnt), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1; b_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1 chk($sformatf("t6_post%0d_rvalid", i), 32'(b_rvalid), 32'd0);
      end
      @(negedge clk);
      b_req = 1'b1; b_addr = 34'h0;
      #1 chk("t6_cnt_gnt0", 32'(b_gnt), 32'd1);
      @(negedge clk);
      b_addr = 34'h4;
      #1 chk("t6_cnt_gnt1", 32'(b_gnt), 32'd1);
      @(negedge clk);
      b_addr = 34'h8;
      #1 chk("t6_cnt_gnt2", 32'(b_gnt), 32'd0);
      @(negedge clk);
      b_req = 1'b0;
      repeat (4) @(negedge clk);

      // Offset window: base 0x1000, 16 words.
      @(negedge clk);
      c_req = 1'b1; c_we = 1'b1; c_addr = 34'h1000; c_be = 4'hF; c_wdata = 32'h1111_1111;
      #1 chk("t4_st_lo_gnt", 32'(c_gnt), 32'd1);
      @(negedge clk);
      c_addr = 34'h103C; c_wdata = 32'h2222_2222;
      #1 chk("t4_st_hi_gnt", 32'(c_gnt), 32'd1);
      chk("t4_st_lo_oor", 32'(c_oor), 32'd0);
      @(negedge clk);
      c_we = 1'b0; c_addr = 34'h1040;
      #1 chk("t4_ld_oor_gnt", 32'(c_gnt), 32'd1);
      @(negedge clk);
      c_we = 1'b1; c_addr = 34'h0FFC; c_wdata = 32'h5555_5555;
      #1 chk("t4_ld_oor_rdata", c_rdata, 32'hDEAD_BEEF);
      chk("t4_ld_oor_pulse", 32'(c_oor), 32'd1);
      @(negedge clk);
      c_we = 1'b0; c_addr = 34'h1000;
      #1 chk("t4_st_oor_rdata", c_rdata, 32'h0);
      chk("t4_st_oor_pulse", 32'(c_oor), 32'd1);
      @(negedge clk);
      c_addr = 34'h103C;
      #1 chk("t4_lo_rdata", c_rdata, 32'h1111_1111);
      chk("t4_lo_oor", 32'(c_oor), 32'd0);
      @(negedge clk);
      c_addr = 34'h0FFC;
      #1 chk("t4_hi_rdata", c_rdata, 32'h2222_2222);
      @(negedge clk);
      c_req = 1'b0;
      #1 chk("t4_below_rdata", c_rdata, 32'hDEAD_BEEF);
      chk("t4_below_oor", 32'(c_oor), 32'd1);
      @(negedge clk);
      #1 chk("t4_idle_oor", 32'(c_oor), 32'd0);
      chk("t4_idle_rvalid", 32'(c_rvalid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
